// File: rtl/fifo_rd_stream_adapter_if.sv
// rtl/fifo_rd_stream_adapter_if.sv - valid/ready stream bundle with packet framing
interface fifo_rd_stream_adapter_if #(
    parameter int DW = 32
);
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// rtl/fifo_rd_stream_adapter.sv - sync_fifo read-side drain into a framed valid/ready stream
// Optional pkt_cnt/word_cnt statistics outputs under FIFO_RD_STREAM_STAT_EN.
module fifo_rd_stream_adapter #(
    parameter int DW      = 32,
    parameter int PKT_LEN = 16,
    parameter int PW      = 4
) (
    input  logic                            rclk,
    input  logic                            rst,
    input  logic                            enable,
    output logic                            renable,
    input  logic [DW-1:0]                   rdata,
    input  logic                            empty,
    fifo_rd_stream_adapter_if.master        strm,
    output logic                            busy
`ifdef FIFO_RD_STREAM_STAT_EN
    ,
    output logic [15:0]                     pkt_cnt,
    output logic [31:0]                     word_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    localparam logic [PW-1:0] LAST_BEAT = PW'(PKT_LEN - 1);

    state_t          state, state_nxt;
    logic [1:0]      occ;
    logic            rd_pend;
    logic [PW-1:0]   beat_cnt;
    logic            hd;
    logic [DW-1:0]   mem_data [2];
    logic            mem_last [2];
    logic [1:0]      fill;
    logic            tl;
    logic            pop;

    assign pop  = strm.out_valid && strm.out_ready;
    // Words already in the buffer plus the one still coming back from the FIFO.
    assign fill = occ + 2'(rd_pend);
    // A capture only ever happens with occ <= 1, so the tail is the slot after the head.
    assign tl   = hd ^ occ[0];

    assign strm.out_valid = (occ != 2'd0);
    assign strm.out_data  = mem_data[hd];
    assign strm.out_last  = strm.out_valid && mem_last[hd];
    assign busy           = (state != IDLE);

    always_comb begin
        state_nxt = state;
        renable   = 1'b0;
        unique case (state)
            IDLE: begin
                if (enable) state_nxt = RUN;
            end
            RUN: begin
                renable = !empty && ((fill < 2'd2) || pop);
                if (!enable) state_nxt = STOP;
            end
            STOP: begin
                if (enable)                         state_nxt = RUN;
                else if (occ == 2'd0 && !rd_pend)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state       <= IDLE;
            occ         <= 2'd0;
            rd_pend     <= 1'b0;
            beat_cnt    <= '0;
            hd          <= 1'b0;
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last[0] <= 1'b0;
            mem_last[1] <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= renable;
            if (rd_pend) begin
                mem_data[tl] <= rdata;
                mem_last[tl] <= (beat_cnt == LAST_BEAT);
                beat_cnt     <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + PW'(1);
            end
            if (pop) hd <= ~hd;
            occ <= occ + 2'(rd_pend) - 2'(pop);
        end
    end

`ifdef FIFO_RD_STREAM_STAT_EN
    always_ff @(posedge rclk) begin
        if (rst) begin
            pkt_cnt  <= 16'd0;
            word_cnt <= 32'd0;
        end else if (pop) begin
            word_cnt <= word_cnt + 32'd1;
            if (strm.out_last) pkt_cnt <= pkt_cnt + 16'd1;
        end
    end
`endif

endmodule
